ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the St.PU five-stage pipeline, directly downstream of the decode stage via the ID/EX register. Consumes the decoded operation, operand values and write destination, and produces the GPR write-back value and HI/LO updates toward MEM. Logic, shift, arithmetic, move and multiply complete in the same cycle. DIV/DIVU run on an iterative 32-step divider that stalls the pipeline through `stallreq_from_ex`.

## Interface
Parameters: none. Widths come from `Defines.vh` buses.

Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high (`RstEnable` = 1'b1).

- `clk` in 1: pipeline clock
- `rst` in 1: synchronous active-high reset
- `aluop_i` in `AluOpBus`: operation code from ID/EX
- `alusel_i` in `AluSelBus`: result type select
- `reg1_i`, `reg2_i` in 32: operands; already carry the immediate or shift amount when decode disabled the register read
- `wd_i` in 5, `wreg_i` in 1: GPR destination and write enable
- `hi_i`, `lo_i` in 32: architectural HI/LO
- `mem_whilo_i` in 1, `mem_hi_i`, `mem_lo_i` in 32: HI/LO write from MEM stage
- `wb_whilo_i` in 1, `wb_hi_i`, `wb_lo_i` in 32: HI/LO write from WB stage
- `flush_i` in 1: cancels any in-flight divide
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32: GPR write-back
- `whilo_o` out 1, `hi_o`, `lo_o` out 32: HI/LO write request
- `stallreq_from_ex` out 1: stall request to pipeline control

## Operation
Reset values:
- While `rst`, all outputs are 0.
- Divider returns to IDLE with its counter at 0.

GPR write-back:
- `wd_o` = `wd_i`.
- `wreg_o` = `wreg_i`, except ADD/ADDI/SUB with signed overflow, which force `wreg_o` = 0.

Logic and shift:
- OR, AND, XOR, NOR operate on `reg1_i` and `reg2_i`.
- SLL, SRL and SRA shift `reg2_i` by `reg1_i[4:0]`. SRA is arithmetic.

Arithmetic:
- ADD/ADDU produce `reg1_i + reg2_i`. SUB/SUBU produce `reg1_i - reg2_i`.
- SLT is a signed compare and SLTU an unsigned compare. Both return 32'h1 or 32'h0.

HI/LO forwarding: the value read is `mem_*` if `mem_whilo_i`, else `wb_*` if `wb_whilo_i`, else `hi_i`/`lo_i`.

Move:
- MFHI/MFLO: `wdata_o` = forwarded HI/LO.
- MTHI: `whilo_o` = 1, `hi_o` = `reg1_i`, `lo_o` = forwarded LO.
- MTLO is the mirror of MTHI.

Multiply: MULT (signed) and MULTU (unsigned) form a 64-bit product. `whilo_o` = 1, `hi_o` = product[63:32], `lo_o` = product[31:0].

Unknown `alusel_i`: `wdata_o` = 0.

Divider FSM, states IDLE, BUSY, DONE:
- IDLE on DIV/DIVU with `flush_i` low:
  - `stallreq_from_ex` = 1.
  - If divisor = 0, next state is DONE with a zero result.
  - Otherwise latch operand magnitudes (absolute values for DIV), clear the counter, and go to BUSY.
- BUSY: one restoring shift-subtract step per cycle. `stallreq_from_ex` = 1. After the 32nd step (counter = 31), go to DONE.
- DONE:
  - Apply signs for DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - `lo_o` = quotient, `hi_o` = remainder, `whilo_o` = 1, `stallreq_from_ex` = 0.
  - Next state is IDLE.
- `flush_i` in any state forces `stallreq_from_ex` = 0 combinationally and IDLE at the next edge, discarding partial state.
- Changes on `aluop_i` while BUSY are ignored.

## Timing
- All non-divide operations: 0-cycle combinational latency.
- DIV/DIVU, nonzero divisor:
  - Accept cycle, then 32 BUSY cycles, then DONE.
  - Stall is high for 33 cycles; the result is valid in cycle 34.
  - Next instruction is accepted in cycle 35.
- Divide by zero: stall for 1 cycle; DONE with `hi_o` = `lo_o` = 0.
- Control holds ID/EX while stalled, so `aluop_i` remains DIV until DONE. DONE returning to IDLE prevents re-triggering.

## Configuration
- `EX_DIV_EN` defined: divider FSM and sub-module are present.
- `EX_DIV_EN` undefined:
  - DIV/DIVU behave as NOP: `whilo_o` = 0.
  - `stallreq_from_ex` is tied to 0 and no divider state exists.

## Structure
- `Defines.vh` holds:
  - opcodes, `AluOpBus`/`AluSelBus`, `EXE_*_OP` and `EXE_RES_*`;
  - new divider state codes `DivFree`, `DivOn`, `DivEnd`, `DivByZero`.
- Sub-module `div_unit` holds the FSM, counter and 65-bit shift register. Interface: `start`, `signed_div`, `op1`, `op2`, `annul`, `result[63:0]`, `ready`.

## Test plan
- ADD `0x7FFFFFFF` + `0x1`: `wreg_o` = 0. ADDU with the same operands: `wdata_o` = `0x80000000`, `wreg_o` = 1.
- MULT `0xFFFFFFFF` × `0x2`: `hi_o` = `0xFFFFFFFF`, `lo_o` = `0xFFFFFFFE`, `whilo_o` = 1. MULTU with the same operands: `hi_o` = `0x1`, `lo_o` = `0xFFFFFFFE`.
- DIV −7 / 2: stall for 33 cycles, then `lo_o` = `0xFFFFFFFD` and `hi_o` = `0xFFFFFFFF`.
- DIVU `0xFFFFFFFF` / `0x10`: `lo_o` = `0x0FFFFFFF`, `hi_o` = `0xF`. Divisor 0: 1-cycle stall, then HI = LO = 0.
- MFHI with `mem_whilo_i` = 1, `mem_hi_i` = `0x1234`, `wb_whilo_i` = 1, `wb_hi_i` = `0x5678`, `hi_i` = 0: `wdata_o` = `0x1234`.
- `flush_i` in BUSY cycle 10: stall drops the same cycle and the FSM is IDLE next cycle. A following DIV takes the full 33-cycle stall.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - opcodes, result selects and divider state codes for ex_stage
package ex_stage_pkg;

  localparam int ALU_OP_W  = 8;
  localparam int ALU_SEL_W = 3;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [ALU_OP_W-1:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [ALU_OP_W-1:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [ALU_OP_W-1:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [ALU_OP_W-1:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [ALU_OP_W-1:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP  = 8'b00011011;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;

  // DivByZero is reserved; a zero divisor goes straight to DivEnd with a cleared result
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// rtl/ex_stage_div_unit.sv - 32-step restoring divider (module div_unit) used by ex_stage
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic        neg_q, neg_r;
  logic [33:0] trial;
  logic [31:0] mag1, mag2, quo, rem;

  assign mag1  = (signed_div && op1[31]) ? (~op1 + 32'd1) : op1;
  assign mag2  = (signed_div && op2[31]) ? (~op2 + 32'd1) : op2;
  // partial remainder with next dividend bit is dividend[64:32], up to 33 bits wide
  assign trial = {1'b0, dividend[64:32]} - {2'b00, divisor};

  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DivFree: if (start) state_nxt = (op2 == 32'd0) ? DivEnd : DivOn;
      DivOn:   if (cnt == 5'd31) state_nxt = DivEnd;
      DivEnd:  state_nxt = DivFree;
      default: state_nxt = DivFree;
    endcase
    if (annul) state_nxt = DivFree;
  end

  always_ff @(posedge clk) begin
    if (rst || annul) begin
      cnt      <= 5'd0;
      dividend <= 65'd0;
      divisor  <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        DivFree: if (start) begin
          cnt      <= 5'd0;
          dividend <= (op2 == 32'd0) ? 65'd0 : {32'd0, mag1, 1'b0};
          divisor  <= mag2;
          neg_q    <= signed_div && (op1[31] ^ op2[31]);
          neg_r    <= signed_div && op1[31];
        end
        DivOn: begin
          dividend <= trial[33] ? {dividend[63:0], 1'b0}
                                : {trial[31:0], dividend[31:0], 1'b1};
          cnt      <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign quo    = dividend[31:0];
  assign rem    = dividend[64:33];
  assign result = {(neg_r ? (~rem + 32'd1) : rem), (neg_q ? (~quo + 32'd1) : quo)};
  assign ready  = (state == DivEnd);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - St.PU execute stage: ALU, shifts, HI/LO moves, multiply
// and an optional iterative divider enabled by the EX_DIV_EN macro.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [ALU_SEL_W-1:0] alusel_i,
  input  logic [31:0]          reg1_i,
  input  logic [31:0]          reg2_i,
  input  logic [4:0]           wd_i,
  input  logic                 wreg_i,
  input  logic [31:0]          hi_i,
  input  logic [31:0]          lo_i,
  input  logic                 mem_whilo_i,
  input  logic [31:0]          mem_hi_i,
  input  logic [31:0]          mem_lo_i,
  input  logic                 wb_whilo_i,
  input  logic [31:0]          wb_hi_i,
  input  logic [31:0]          wb_lo_i,
  input  logic                 flush_i,
  output logic [4:0]           wd_o,
  output logic                 wreg_o,
  output logic [31:0]          wdata_o,
  output logic                 whilo_o,
  output logic [31:0]          hi_o,
  output logic [31:0]          lo_o,
  output logic                 stallreq_from_ex
);

  logic [31:0] hi_fwd, lo_fwd;
  logic [31:0] logic_res, shift_res, arith_res, move_res;
  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf, ovf_trap;
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, product;
  logic        div_stall, div_ready;
  logic [63:0] div_result;

  // youngest in-flight HI/LO write wins
  always_comb begin
    hi_fwd = hi_i;
    lo_fwd = lo_i;
    if (mem_whilo_i) begin
      hi_fwd = mem_hi_i;
      lo_fwd = mem_lo_i;
    end else if (wb_whilo_i) begin
      hi_fwd = wb_hi_i;
      lo_fwd = wb_lo_i;
    end
  end

  always_comb begin
    logic_res = 32'd0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'd0;
    endcase
  end

  always_comb begin
    shift_res = 32'd0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = 32'd0;
    endcase
  end

  assign sum      = reg1_i + reg2_i;
  assign diff     = reg1_i - reg2_i;
  assign add_ovf  = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
  assign sub_ovf  = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
  assign ovf_trap = (((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_ADDI_OP)) && add_ovf)
                  || ((aluop_i == EXE_SUB_OP) && sub_ovf);

  always_comb begin
    arith_res = 32'd0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: arith_res = sum;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff;
      EXE_SLT_OP:  arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {31'd0, (reg1_i < reg2_i)};
      default:     arith_res = 32'd0;
    endcase
  end

  always_comb begin
    move_res = 32'd0;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_fwd;
      EXE_MFLO_OP: move_res = lo_fwd;
      default:     move_res = 32'd0;
    endcase
  end

  // one 64-bit multiplier; sign-extending the operands makes the low 64 bits the signed product
  assign mul_signed = (aluop_i == EXE_MULT_OP);
  assign mul_a      = {{32{mul_signed & reg1_i[31]}}, reg1_i};
  assign mul_b      = {{32{mul_signed & reg2_i[31]}}, reg2_i};
  assign product    = mul_a * mul_b;

`ifdef EX_DIV_EN
  logic div_op;
  assign div_op = is_div_op(aluop_i);

  div_unit u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_op && !flush_i),
    .signed_div (aluop_i == EXE_DIV_OP),
    .op1        (reg1_i),
    .op2        (reg2_i),
    .annul      (flush_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  assign div_stall = div_op && !div_ready && !flush_i;
`else
  logic unused_div;
  assign unused_div = clk ^ flush_i;
  assign div_stall  = 1'b0;
  assign div_ready  = 1'b0;
  assign div_result = 64'd0;
`endif

  always_comb begin
    wd_o             = 5'd0;
    wreg_o           = 1'b0;
    wdata_o          = 32'd0;
    whilo_o          = 1'b0;
    hi_o             = 32'd0;
    lo_o             = 32'd0;
    stallreq_from_ex = 1'b0;
    if (!rst) begin
      wd_o             = wd_i;
      wreg_o           = wreg_i && !ovf_trap;
      stallreq_from_ex = div_stall;
      case (alusel_i)
        EXE_RES_LOGIC:      wdata_o = logic_res;
        EXE_RES_SHIFT:      wdata_o = shift_res;
        EXE_RES_MOVE:       wdata_o = move_res;
        EXE_RES_ARITHMETIC: wdata_o = arith_res;
        default:            wdata_o = 32'd0;
      endcase
      case (aluop_i)
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_o = 1'b1;
          hi_o    = product[63:32];
          lo_o    = product[31:0];
        end
        EXE_MTHI_OP: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_fwd;
        end
        EXE_MTLO_OP: begin
          whilo_o = 1'b1;
          hi_o    = hi_fwd;
          lo_o    = reg1_i;
        end
        EXE_DIV_OP, EXE_DIVU_OP: begin
          whilo_o = div_ready;
          hi_o    = div_ready ? div_result[63:32] : 32'd0;
          lo_o    = div_ready ? div_result[31:0] : 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with a behavioural reference model
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2, hi, lo, mem_hi, mem_lo, wb_hi, wb_lo;
  logic [4:0]  wd;
  logic        wreg, mem_whilo, wb_whilo, flush;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_from_ex;
  logic [31:0] wdata_o, hi_o, lo_o;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   stall_cnt = 0;

  logic [10:0] op_tab [0:23] = '{
    {EXE_OR_OP, EXE_RES_LOGIC},    {EXE_AND_OP, EXE_RES_LOGIC},   {EXE_XOR_OP, EXE_RES_LOGIC},
    {EXE_NOR_OP, EXE_RES_LOGIC},   {EXE_SLL_OP, EXE_RES_SHIFT},   {EXE_SRL_OP, EXE_RES_SHIFT},
    {EXE_SRA_OP, EXE_RES_SHIFT},   {EXE_SLT_OP, EXE_RES_ARITHMETIC}, {EXE_SLTU_OP, EXE_RES_ARITHMETIC},
    {EXE_ADD_OP, EXE_RES_ARITHMETIC}, {EXE_ADDU_OP, EXE_RES_ARITHMETIC}, {EXE_SUB_OP, EXE_RES_ARITHMETIC},
    {EXE_SUBU_OP, EXE_RES_ARITHMETIC}, {EXE_ADDI_OP, EXE_RES_ARITHMETIC}, {EXE_ADDIU_OP, EXE_RES_ARITHMETIC},
    {EXE_MFHI_OP, EXE_RES_MOVE},   {EXE_MFLO_OP, EXE_RES_MOVE},   {EXE_MTHI_OP, EXE_RES_NOP},
    {EXE_MTLO_OP, EXE_RES_NOP},    {EXE_MULT_OP, EXE_RES_NOP},    {EXE_MULTU_OP, EXE_RES_NOP},
    {EXE_DIV_OP, EXE_RES_NOP},     {EXE_DIVU_OP, EXE_RES_NOP},    {EXE_OR_OP, 3'b111}
  };

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel), .reg1_i(reg1), .reg2_i(reg2),
    .wd_i(wd), .wreg_i(wreg), .hi_i(hi), .lo_i(lo),
    .mem_whilo_i(mem_whilo), .mem_hi_i(mem_hi), .mem_lo_i(mem_lo),
    .wb_whilo_i(wb_whilo), .wb_hi_i(wb_hi), .wb_lo_i(wb_lo), .flush_i(flush),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_from_ex(stallreq_from_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: MIPS semantics computed with wide integer arithmetic
  function automatic exp_t model();
    exp_t e;
    longint a_s, b_s, s, q, r;
    logic [31:0] hf, lf;
    logic [63:0] p;
    e.wd = 5'd0; e.wreg = 1'b0; e.wdata = 32'd0; e.whilo = 1'b0;
    e.hi = 32'd0; e.lo = 32'd0; e.stalls = 0;
    if (rst) return e;
    a_s = longint'($signed(reg1));
    b_s = longint'($signed(reg2));
    hf = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hi);
    lf = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : lo);
    e.wd = wd;
    e.wreg = wreg;
    case (alusel)
      EXE_RES_LOGIC: case (aluop)
        EXE_OR_OP:  e.wdata = reg1 | reg2;
        EXE_AND_OP: e.wdata = reg1 & reg2;
        EXE_XOR_OP: e.wdata = reg1 ^ reg2;
        EXE_NOR_OP: e.wdata = ~(reg1 | reg2);
        default: ;
      endcase
      EXE_RES_SHIFT: case (aluop)
        EXE_SLL_OP: e.wdata = reg2 << reg1[4:0];
        EXE_SRL_OP: e.wdata = reg2 >> reg1[4:0];
        EXE_SRA_OP: e.wdata = 32'(b_s >>> reg1[4:0]);
        default: ;
      endcase
      EXE_RES_MOVE: e.wdata = (aluop == EXE_MFHI_OP) ? hf : ((aluop == EXE_MFLO_OP) ? lf : 32'd0);
      EXE_RES_ARITHMETIC: case (aluop)
        EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: begin
          s = a_s + b_s;
          e.wdata = 32'(s);
          if ((aluop == EXE_ADD_OP || aluop == EXE_ADDI_OP) && (s > 64'sd2147483647 || s < -64'sd2147483648))
            e.wreg = 1'b0;
        end
        EXE_SUB_OP, EXE_SUBU_OP: begin
          s = a_s - b_s;
          e.wdata = 32'(s);
          if (aluop == EXE_SUB_OP && (s > 64'sd2147483647 || s < -64'sd2147483648)) e.wreg = 1'b0;
        end
        EXE_SLT_OP:  e.wdata = (a_s < b_s) ? 32'd1 : 32'd0;
        EXE_SLTU_OP: e.wdata = (longint'(reg1) < longint'(reg2)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      default: ;
    endcase
    case (aluop)
      EXE_MULT_OP:  begin p = 64'(a_s * b_s); e.whilo = 1'b1; e.hi = p[63:32]; e.lo = p[31:0]; end
      EXE_MULTU_OP: begin p = {32'd0, reg1} * {32'd0, reg2}; e.whilo = 1'b1; e.hi = p[63:32]; e.lo = p[31:0]; end
      EXE_MTHI_OP:  begin e.whilo = 1'b1; e.hi = reg1; e.lo = lf; end
      EXE_MTLO_OP:  begin e.whilo = 1'b1; e.hi = hf; e.lo = reg1; end
      EXE_DIV_OP, EXE_DIVU_OP: if (DIV_EN) begin
        e.whilo = 1'b1;
        if (reg2 == 32'd0) begin
          e.stalls = 1;
        end else begin
          e.stalls = 33;
          if (aluop == EXE_DIV_OP) begin q = a_s / b_s; r = a_s % b_s; end
          else begin q = longint'(reg1) / longint'(reg2); r = longint'(reg1) % longint'(reg2); end
          e.lo = 32'(q);
          e.hi = 32'(r);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %h, expected %h", name, n_pop, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      if (stallreq_from_ex) begin
        stall_cnt++;
      end else begin
        e = exp_q.pop_front();
        check("wd", 32'(wd_o), 32'(e.wd));
        check("wreg", 32'(wreg_o), 32'(e.wreg));
        check("wdata", wdata_o, e.wdata);
        check("whilo", 32'(whilo_o), 32'(e.whilo));
        check("hi", hi_o, e.hi);
        check("lo", lo_o, e.lo);
        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        stall_cnt = 0;
        n_pop++;
      end
    end
  end

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // called just after a posedge; randomises side inputs which the caller may override
  task automatic start_txn(input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] b);
    #1;
    aluop = op; alusel = sel; reg1 = a; reg2 = b;
    wd = 5'($urandom); wreg = 1'($urandom);
    hi = $urandom; lo = $urandom;
    mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
    wb_whilo = 1'($urandom); wb_hi = $urandom; wb_lo = $urandom;
  endtask

  task automatic finish_txn();
    int target;
    exp_q.push_back(model());
    target = n_pop + 1;
    for (int i = 0; i < 200 && n_pop < target; i++) @(posedge clk);
    if (n_pop < target) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout (txn %0d): no result within 200 cycles, stall=%b", n_pop, stallreq_from_ex);
      exp_q.delete();
      stall_cnt = 0;
    end
  endtask

  task automatic txn(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    start_txn(op, sel, a, b);
    finish_txn();
  endtask

  initial begin
    int k, cnt;
    rst = 1'b1; flush = 1'b0;
    aluop = EXE_NOP_OP; alusel = EXE_RES_NOP; reg1 = 0; reg2 = 0; wd = 0; wreg = 0;
    hi = 0; lo = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0; wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    repeat (3) @(posedge clk);
    txn(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2);
    txn(EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_5678, 32'h0F0F_0000);
    #1 rst = 1'b0;

    txn(EXE_ADD_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1);
    txn(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'h1);
    txn(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h0, 32'h8000_0000);
    txn(EXE_SUB_OP, EXE_RES_ARITHMETIC, 32'h8000_0000, 32'h1);
    txn(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2);
    txn(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h2);
    txn(EXE_SRA_OP, EXE_RES_SHIFT, 32'd31, 32'h8000_0000);
    txn(EXE_SLL_OP, EXE_RES_SHIFT, 32'd32, 32'hA5A5_0001);
    txn(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1);
    txn(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1);
    txn(EXE_XOR_OP, 3'b110, 32'hFFFF_0000, 32'h00FF_FF00);
    txn(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'h2);
    txn(EXE_DIVU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'h10);
    txn(EXE_DIVU_OP, EXE_RES_NOP, 32'h1234, 32'h0);
    txn(EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF);

    start_txn(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    mem_whilo = 1'b1; mem_hi = 32'h1234; wb_whilo = 1'b1; wb_hi = 32'h5678; hi = 32'h0;
    finish_txn();
    start_txn(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    mem_whilo = 1'b0; wb_whilo = 1'b1;
    finish_txn();
    start_txn(EXE_MTHI_OP, EXE_RES_NOP, 32'hCAFE_0001, 32'h0);
    mem_whilo = 1'b0; wb_whilo = 1'b0;
    finish_txn();
    start_txn(EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFE_0002, 32'h0);
    mem_whilo = 1'b1;
    finish_txn();

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 23);
      txn(op_tab[k][10:3], op_tab[k][2:0], rnd32(), rnd32());
    end

`ifdef EX_DIV_EN
    #1 aluop = EXE_DIV_OP; alusel = EXE_RES_NOP; reg1 = 32'd100; reg2 = 32'd7; flush = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_stall_drop", 32'(stallreq_from_ex), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_from_ex) break;
      cnt++;
    end
    check("refetch_stall_cycles", 32'(cnt), 32'd33);
    check("refetch_lo", lo_o, 32'd14);
    check("refetch_hi", hi_o, 32'd2);
    check("refetch_whilo", 32'(whilo_o), 32'd1);
    @(posedge clk);
    #1 aluop = EXE_NOP_OP;
`endif

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
